// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V sequencing FSM: steps one instruction through fetch, decode,
// execute, memory and write-back, with a memory-wait timeout and a retire counter.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        memReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        regWrite,
  output logic        memoryRead,
  output logic        memoryWrite,
  output logic        memoryToRegister,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        PCSource,
  output logic        halted,
  output logic        timeout,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_EXEC_R    = 4'd6;
  localparam logic [3:0] ST_EXEC_I    = 4'd7;
  localparam logic [3:0] ST_ALU_WB    = 4'd8;
  localparam logic [3:0] ST_BRANCH    = 4'd9;
  localparam logic [3:0] ST_HALT      = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

  logic [3:0]  state_q;
  logic [3:0]  state_d;
  logic [7:0]  wait_cnt_q;
  logic [31:0] retired_q;
  logic        timeout_q;
  logic        wait_state;
  logic        wait_expire;
  logic        retire_evt;
  logic        timeout_evt;

  // Memory handshake: a request (memoryRead/memoryWrite) stays asserted while the FSM
  // sits in a wait state; the transfer completes in the cycle memReady is 1, and
  // memReady is ignored in every other state.
  assign wait_state  = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                       (state_q == ST_MEM_WRITE);
  assign wait_expire = wait_state && !memReady &&
                       (({1'b0, wait_cnt_q} + 9'd1) == TIMEOUT_LIMIT);

  always_comb begin
    state_d     = state_q;
    retire_evt  = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (memReady) begin
          state_d = ST_DECODE;
        end else if (wait_expire) begin
          state_d     = ST_HALT;
          timeout_evt = 1'b1;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_R:               state_d = ST_EXEC_R;
          OP_I:               state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
          OP_BRANCH:          state_d = ST_BRANCH;
          default:            state_d = ST_HALT;
        endcase
      end
      ST_MEM_ADDR: begin
        if (opcode == OP_LOAD) begin
          state_d = ST_MEM_READ;
        end else if (opcode == OP_STORE) begin
          state_d = ST_MEM_WRITE;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_MEM_READ: begin
        if (memReady) begin
          state_d = ST_MEM_WB;
        end else if (wait_expire) begin
          state_d     = ST_HALT;
          timeout_evt = 1'b1;
        end
      end
      ST_MEM_WB: begin
        state_d    = ST_FETCH;
        retire_evt = 1'b1;
      end
      ST_MEM_WRITE: begin
        if (memReady) begin
          state_d    = ST_FETCH;
          retire_evt = 1'b1;
        end else if (wait_expire) begin
          state_d     = ST_HALT;
          timeout_evt = 1'b1;
        end
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
      ST_ALU_WB, ST_BRANCH: begin
        state_d    = ST_FETCH;
        retire_evt = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      // Unused encodings are treated as a fault and park the machine.
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= 8'd0;
      retired_q  <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter restarts whenever a state is entered, so each wait state gets a full budget.
      if (state_d != state_q) begin
        wait_cnt_q <= 8'd0;
      end else if (wait_state && !memReady) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (retire_evt) begin
        retired_q <= retired_q + 32'd1;
      end
      if (timeout_evt) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    PCWrite          = 1'b0;
    IRWrite          = 1'b0;
    regWrite         = 1'b0;
    memoryRead       = 1'b0;
    memoryWrite      = 1'b0;
    memoryToRegister = 1'b0;
    ALUSrcA          = 1'b0;
    ALUSrcB          = 2'b00;
    ALUOp            = 2'b00;
    PCSource         = 1'b0;
    halted           = 1'b0;
    // Every control output is held low while reset is asserted, FETCH included.
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          memoryRead = 1'b1;
          ALUSrcB    = 2'b01;
          IRWrite    = memReady;
          PCWrite    = memReady;
        end
        ST_DECODE: begin
          ALUSrcB = 2'b10;
        end
        ST_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ST_MEM_READ: begin
          memoryRead = 1'b1;
        end
        ST_MEM_WB: begin
          regWrite         = 1'b1;
          memoryToRegister = 1'b1;
        end
        ST_MEM_WRITE: begin
          memoryWrite = 1'b1;
        end
        ST_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ST_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
        end
        ST_ALU_WB: begin
          regWrite = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 1'b1;
          PCWrite  = zero;
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign timeout = timeout_q;

  a_no_dual_write: assert property (@(posedge clock) disable iff (!reset)
    !(regWrite && memoryWrite));
  a_halt_absorbs: assert property (@(posedge clock) disable iff (!reset)
    (state_q == ST_HALT) |=> (state_q == ST_HALT));

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level reference model
// schedules per-cycle expectations into a queue that a negedge monitor drains.
module tb_multicycle_controller;

  localparam int T = 4;
  localparam int W = 50;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3, S_MEM_WB = 4;
  localparam int S_MEM_WRITE = 5, S_EXEC_R = 6, S_EXEC_I = 7, S_ALU_WB = 8, S_BRANCH = 9;
  localparam int S_HALT = 15;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  logic        clock;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        memReady;
  logic        PCWrite, IRWrite, regWrite, memoryRead, memoryWrite, memoryToRegister;
  logic        ALUSrcA, PCSource, halted, timeout;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [31:0] retired;

  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [31:0]  model_ret;
  bit           model_to;
  bit           cur_z;

  multicycle_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .regWrite(regWrite), .memoryRead(memoryRead),
    .memoryWrite(memoryWrite), .memoryToRegister(memoryToRegister), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .halted(halted),
    .timeout(timeout), .state(state), .retired(retired)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [W-1:0] obs_vec();
    return {state, PCWrite, IRWrite, regWrite, memoryRead, memoryWrite, memoryToRegister,
            ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, timeout, retired};
  endfunction

  // Expected outputs for one cycle in a given phase of the instruction flow.
  function automatic logic [W-1:0] ref_vec(int st, bit rdy, bit z, bit in_rst, bit to,
                                           logic [31:0] ret);
    logic pcw, irw, rw, mr, mw, m2r, asa, pcs, hlt;
    logic [1:0] asb, aop;
    pcw = 0; irw = 0; rw = 0; mr = 0; mw = 0; m2r = 0; asa = 0; pcs = 0; hlt = 0;
    asb = 2'b00; aop = 2'b00;
    if (in_rst) return {4'd0, 14'd0, 32'd0};
    case (st)
      S_FETCH:     begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:    asb = 2'b10;
      S_EXEC_R:    begin asa = 1; aop = 2'b10; end
      S_EXEC_I:    begin asa = 1; asb = 2'b10; aop = 2'b10; end
      S_ALU_WB:    rw = 1;
      S_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      S_MEM_READ:  mr = 1;
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WRITE: mw = 1;
      S_BRANCH:    begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; end
      S_HALT:      hlt = 1;
      default:     ;
    endcase
    return {4'(st), pcw, irw, rw, mr, mw, m2r, asa, asb, aop, pcs, hlt, to, ret};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: dut {state,ctl,ret}=%h expected %h", name, $time, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (exp_q.size() != 0) check("cycle", obs_vec(), exp_q.pop_front());
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic bit supported(logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
  endfunction

  // One clock cycle: drive inputs, queue the expectation, advance, update the model.
  task automatic cyc(input int st, input bit rdy, input bit ret_after, input logic [6:0] op,
                     input bit preload = 1'b0);
    opcode   = op;
    zero     = cur_z;
    memReady = rdy;
    if (preload) begin
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      model_ret = 32'hFFFF_FFFF;
    end
    exp_q.push_back(ref_vec(st, rdy, cur_z, 1'b0, model_to, model_ret));
    @(posedge clock);
    #1;
    if (ret_after) model_ret = model_ret + 32'd1;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      memReady = rb();
      opcode   = rnd_op();
      exp_q.push_back(ref_vec(S_FETCH, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
      @(posedge clock);
      #1;
    end
    reset     = 1'b1;
    model_ret = 32'd0;
    model_to  = 1'b0;
  endtask

  task automatic do_fetch(input int fw);
    for (int i = 0; i < fw; i++) cyc(S_FETCH, 1'b0, 1'b0, rnd_op());
    cyc(S_FETCH, 1'b1, 1'b0, rnd_op());
  endtask

  task automatic run_instr(input int kind, input int fw, input int mw, input bit z,
                           input bit wrap = 1'b0);
    logic [6:0] op;
    case (kind)
      K_R: op = OP_R;
      K_I: op = OP_I;
      K_LD: op = OP_LD;
      K_ST: op = OP_ST;
      default: op = OP_BR;
    endcase
    cur_z = z;
    do_fetch(fw);
    cyc(S_DECODE, rb(), 1'b0, op);
    case (kind)
      K_R: begin cyc(S_EXEC_R, rb(), 1'b0, op); cyc(S_ALU_WB, rb(), 1'b1, op, wrap); end
      K_I: begin cyc(S_EXEC_I, rb(), 1'b0, op); cyc(S_ALU_WB, rb(), 1'b1, op, wrap); end
      K_LD: begin
        cyc(S_MEM_ADDR, rb(), 1'b0, op);
        for (int i = 0; i < mw; i++) cyc(S_MEM_READ, 1'b0, 1'b0, op);
        cyc(S_MEM_READ, 1'b1, 1'b0, op);
        cyc(S_MEM_WB, rb(), 1'b1, op);
      end
      K_ST: begin
        cyc(S_MEM_ADDR, rb(), 1'b0, op);
        for (int i = 0; i < mw; i++) cyc(S_MEM_WRITE, 1'b0, 1'b0, op);
        cyc(S_MEM_WRITE, 1'b1, 1'b1, op);
      end
      default: cyc(S_BRANCH, rb(), 1'b1, op);
    endcase
  endtask

  task automatic run_bad(input logic [6:0] op);
    cur_z = rb();
    do_fetch(0);
    cyc(S_DECODE, rb(), 1'b0, op);
    repeat (3) cyc(S_HALT, rb(), 1'b0, op);
    reset_cycles(2);
  endtask

  task automatic run_timeout(input bit in_fetch);
    cur_z = 1'b0;
    if (in_fetch) begin
      for (int i = 0; i < T; i++) cyc(S_FETCH, 1'b0, 1'b0, rnd_op());
    end else begin
      do_fetch(0);
      cyc(S_DECODE, rb(), 1'b0, OP_ST);
      cyc(S_MEM_ADDR, rb(), 1'b0, OP_ST);
      for (int i = 0; i < T; i++) cyc(S_MEM_WRITE, 1'b0, 1'b0, OP_ST);
    end
    model_to = 1'b1;
    repeat (3) cyc(S_HALT, rb(), 1'b0, rnd_op());
    reset_cycles(2);
  endtask

  task automatic mid_reset();
    cur_z = 1'b0;
    do_fetch(1);
    cyc(S_DECODE, rb(), 1'b0, OP_ST);
    opcode   = OP_ST;
    memReady = rb();
    exp_q.push_back(ref_vec(S_MEM_ADDR, 1'b0, 1'b0, 1'b0, model_to, model_ret));
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset", obs_vec(), ref_vec(S_FETCH, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
    @(posedge clock);
    #1;
    reset_cycles(1);
  endtask

  // Driver
  initial begin
    logic [6:0] bad;
    reset     = 1'b0;
    opcode    = 7'd0;
    zero      = 1'b0;
    memReady  = 1'b0;
    cur_z     = 1'b0;
    model_ret = 32'd0;
    model_to  = 1'b0;
    @(posedge clock);
    #1;
    reset_cycles(2);
    run_instr(K_R, 0, 0, 1'b0);
    run_instr(K_LD, 0, 3, 1'b0);
    run_instr(K_BR, 0, 0, 1'b1);
    run_instr(K_BR, 0, 0, 1'b0);
    run_instr(K_ST, T - 1, T - 1, 1'b0);
    run_instr(K_LD, T - 1, T - 1, 1'b1);
    run_bad(7'b1111111);
    run_timeout(1'b0);
    run_timeout(1'b1);
    for (int n = 0; n < 80; n++) begin
      run_instr($urandom_range(0, 4), $urandom_range(0, T - 1), $urandom_range(0, T - 1), rb());
    end
    for (int n = 0; n < 4; n++) begin
      bad = rnd_op();
      while (supported(bad)) bad = rnd_op();
      run_bad(bad);
      run_instr($urandom_range(0, 4), $urandom_range(0, T - 1), $urandom_range(0, T - 1), rb());
    end
    run_instr(K_R, 0, 0, 1'b0, 1'b1);
    run_instr(K_I, 1, 0, 1'b0);
    run_instr(K_BR, 0, 0, 1'b1);
    mid_reset();
    run_instr(K_ST, 1, 1, 1'b0);
    run_instr(K_R, 0, 0, 1'b0);
    repeat (3) @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
